// File: rtl/plot_tile_decoder_pkg.sv
// Shared tile geometry and colour constants for the
// 16x16 tile renderers and the plot-stream decoder.
package plot_tile_decoder_pkg;

  localparam int TILE_W = 8;
  localparam int TILE_H = 8;
  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  localparam logic [7:0] XPITCH_DEF = 8'd10;
  localparam logic [6:0] YPITCH_DEF = 7'd7;
  localparam logic [2:0] FG_COLOUR_DEF = 3'b110;
  localparam int THRESH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

endpackage

// File: rtl/plot_tile_decoder_burst_accum.sv
// Counts one 64-pixel tile burst, checks raster order
// and raises a commit strobe on the burst's last pixel.
module tile_burst_accum
  import plot_tile_decoder_pkg::*;
#(
  parameter logic [2:0] FG_COLOUR = FG_COLOUR_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic       commit,
  output logic       bit_val,
  output logic       mixed,
  output logic       coord_mismatch
);

  localparam logic [6:0] THR = 7'(THRESH);

  logic [5:0] pix_cnt;
  logic [6:0] lit_cnt;
  logic [6:0] lit_final;
  logic [7:0] exp_x;
  logic [6:0] exp_y;
  logic       is_lit;

  assign exp_x = base_x + {5'd0, pix_cnt[2:0]};
  assign exp_y = base_y + {4'd0, pix_cnt[5:3]};
  assign is_lit = (colour == FG_COLOUR);
  assign lit_final = lit_cnt + {6'd0, is_lit};

  assign commit = accept && (pix_cnt == 6'd63);
  assign bit_val = (lit_final >= THR);
  assign mixed = (lit_final != 7'd0) && (lit_final != 7'd64);
  assign coord_mismatch = accept &&
    ((x != exp_x) || (y != exp_y));

  // Pixel and lit counters; both restart after each commit
  always_ff @(posedge fastclock) begin
    if (!resetn || clear) begin
      pix_cnt <= 6'd0;
      lit_cnt <= 7'd0;
    end else if (accept) begin
      pix_cnt <= pix_cnt + 6'd1;
      lit_cnt <= commit ? 7'd0 : lit_final;
    end
  end

endmodule

// File: rtl/plot_tile_decoder.sv
// Rebuilds the 16x16 tile bitmap from the VGA plot
// stream and flags bursts that break the tile raster.
module plot_tile_decoder
  import plot_tile_decoder_pkg::*;
#(
  parameter logic [7:0] XPITCH = XPITCH_DEF,
  parameter logic [6:0] YPITCH = YPITCH_DEF,
  parameter logic [2:0] FG_COLOUR = FG_COLOUR_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic        fastclock,
  input  logic        resetn,
  input  logic        start,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_bits,
  output logic        busy,
  output logic        frame_done,
  output logic        coord_err,
  output logic        mixed_err,
  output logic [8:0]  tiles_seen
);

  state_t state, state_next;

  logic [3:0]  tile_col;
  logic [3:0]  tile_row;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [15:0] bitmap [GRID_H];

  logic accept;
  logic commit;
  logic bit_val;
  logic mixed;
  logic coord_mismatch;
  logic last_tile;

  assign accept = plot && !start && (state == S_CAPTURE);
  assign last_tile = (tile_row == 4'd15) && (tile_col == 4'd15);
  assign busy = (state == S_CAPTURE);
  assign frame_done = (state == S_DONE);

  tile_burst_accum #(
    .FG_COLOUR (FG_COLOUR),
    .THRESH    (THRESH)
  ) u_accum (
    .fastclock      (fastclock),
    .resetn         (resetn),
    .clear          (start),
    .accept         (accept),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .base_x         (base_x),
    .base_y         (base_y),
    .commit         (commit),
    .bit_val        (bit_val),
    .mixed          (mixed),
    .coord_mismatch (coord_mismatch)
  );

  // State register
  always_ff @(posedge fastclock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next state: start always (re)arms capture
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!start && commit && last_tile)
          state_next = S_DONE;
      end
      S_DONE: begin
        if (start) state_next = S_CAPTURE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grid position, bitmap, flags and registered readout
  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      rd_bits    <= 16'd0;
      tile_col   <= 4'd0;
      tile_row   <= 4'd0;
      base_x     <= 8'd0;
      base_y     <= 7'd0;
      tiles_seen <= 9'd0;
      coord_err  <= 1'b0;
      mixed_err  <= 1'b0;
      for (int i = 0; i < GRID_H; i++)
        bitmap[i] <= 16'd0;
    end else begin
      rd_bits <= bitmap[rd_row];
      if (start) begin
        tile_col   <= 4'd0;
        tile_row   <= 4'd0;
        base_x     <= 8'd0;
        base_y     <= 7'd0;
        tiles_seen <= 9'd0;
        coord_err  <= 1'b0;
        mixed_err  <= 1'b0;
        for (int i = 0; i < GRID_H; i++)
          bitmap[i] <= 16'd0;
      end else begin
        if (coord_mismatch) coord_err <= 1'b1;
        if (commit) begin
          bitmap[tile_row][4'd15 - tile_col] <= bit_val;
          if (mixed) mixed_err <= 1'b1;
          tiles_seen <= tiles_seen + 9'd1;
          if (tile_col != 4'd15) begin
            tile_col <= tile_col + 4'd1;
            base_x   <= base_x + XPITCH;
          end else begin
            tile_col <= 4'd0;
            base_x   <= 8'd0;
            tile_row <= tile_row + 4'd1;
            base_y   <= base_y + YPITCH;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_tile_decoder.sv
// Directed self-checking bench for plot_tile_decoder:
// full frames, gapped stream, errors, restart, reset.
module tb_plot_tile_decoder;

  logic        fastclock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        plot = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [6:0]  y = 7'd0;
  logic [2:0]  colour = 3'd0;
  logic [3:0]  rd_row = 4'd0;
  logic [15:0] rd_bits;
  logic        busy;
  logic        frame_done;
  logic        coord_err;
  logic        mixed_err;
  logic [8:0]  tiles_seen;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] pat [16];

  plot_tile_decoder dut (
    .fastclock  (fastclock),
    .resetn     (resetn),
    .start      (start),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .rd_row     (rd_row),
    .rd_bits    (rd_bits),
    .busy       (busy),
    .frame_done (frame_done),
    .coord_err  (coord_err),
    .mixed_err  (mixed_err),
    .tiles_seen (tiles_seen)
  );

  always #5 fastclock = ~fastclock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic pix(input int px, input int py,
                     input logic lit);
    plot = 1'b1;
    x = 8'(px);
    y = 7'(py);
    colour = lit ? 3'b110 : 3'b000;
    @(negedge fastclock);
    plot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge fastclock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge fastclock);
    start = 1'b0;
  endtask

  // first nlit pixels are FG, npix pixels in raster order
  task automatic tile(input int r, input int c,
                      input int nlit, input int npix,
                      input bit gaps);
    for (int p = 0; p < npix; p++) begin
      pix(c * 10 + p % 8, r * 7 + p / 8, p < nlit);
      if (gaps && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, 5));
    end
  endtask

  task automatic frame(input bit gaps);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (r == 15 && c == 15) begin
          tile(r, c, pat[r][15-c] ? 64 : 0, 63, gaps);
          chk("busy_before_last", busy, 1);
          chk("done_before_last", frame_done, 0);
          pix(157, 112, pat[r][15-c]);
          chk("done_after_last", frame_done, 1);
          chk("busy_after_last", busy, 0);
        end else begin
          tile(r, c, pat[r][15-c] ? 64 : 0, 64, gaps);
        end
      end
    end
  endtask

  task automatic read_chk(input string tag, input int r,
                          input logic [15:0] exp);
    rd_row = 4'(r);
    @(negedge fastclock);
    chk(tag, rd_bits, exp);
  endtask

  task automatic bitmap_chk(input string tag);
    for (int r = 0; r < 16; r++)
      read_chk($sformatf("%s_row%0d", tag, r), r, pat[r]);
  endtask

  initial begin
    pat[0]  = 16'h8889; pat[1]  = 16'h5155;
    pat[2]  = 16'h2155; pat[3]  = 16'h2155;
    pat[4]  = 16'h2126; pat[5]  = 16'h0000;
    pat[6]  = 16'h0000; pat[7]  = 16'h0000;
    pat[8]  = 16'h4925; pat[9]  = 16'h4935;
    pat[10] = 16'h492D; pat[11] = 16'h5525;
    pat[12] = 16'h6C49; pat[13] = 16'h0000;
    pat[14] = 16'hFFFF; pat[15] = 16'h0001;

    idle(3);
    resetn = 1'b1;
    @(negedge fastclock);
    chk("rst_rd_bits", rd_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_coord", coord_err, 0);
    chk("rst_mixed", mixed_err, 0);
    chk("rst_tiles", tiles_seen, 0);

    // plots while idle are ignored
    tile(0, 0, 64, 64, 1'b0);
    chk("idle_tiles", tiles_seen, 0);
    chk("idle_busy", busy, 0);
    read_chk("idle_row0", 0, 16'h0000);

    // full frame, back-to-back pixels
    pulse_start();
    chk("start_busy", busy, 1);
    frame(1'b0);
    chk("f1_tiles", tiles_seen, 256);
    chk("f1_coord", coord_err, 0);
    chk("f1_mixed", mixed_err, 0);
    read_chk("f1_row0", 0, 16'h8889);
    read_chk("f1_row12", 12, 16'h6C49);

    // same stream with idle gaps
    pulse_start();
    chk("f2_tiles_clr", tiles_seen, 0);
    frame(1'b1);
    chk("f2_tiles", tiles_seen, 256);
    chk("f2_coord", coord_err, 0);
    chk("f2_mixed", mixed_err, 0);
    bitmap_chk("f2");

    // plots in S_DONE are ignored
    tile(0, 0, 32, 64, 1'b0);
    chk("done_tiles", tiles_seen, 256);
    chk("done_mixed", mixed_err, 0);
    chk("done_state", frame_done, 1);
    read_chk("done_row0", 0, 16'h8889);

    // coordinate error on pixel 9 of tile 0
    pulse_start();
    tile(0, 0, 64, 9, 1'b0);
    chk("ce_before", coord_err, 0);
    pix(3, 1, 1'b1);
    chk("ce_after", coord_err, 1);
    for (int p = 10; p < 64; p++)
      pix(p % 8, p / 8, 1'b1);
    chk("ce_tiles", tiles_seen, 1);
    read_chk("ce_row0", 0, 16'h8000);

    // threshold boundary: 32 lit -> 1, 31 lit -> 0
    pulse_start();
    chk("th_coord_clr", coord_err, 0);
    tile(0, 0, 32, 64, 1'b0);
    chk("th32_mixed", mixed_err, 1);
    tile(0, 1, 31, 64, 1'b0);
    chk("th_coord", coord_err, 0);
    read_chk("th_row0", 0, 16'h8000);

    // restart mid-frame after 100 pixels
    pulse_start();
    chk("rs_mixed_clr", mixed_err, 0);
    tile(0, 0, 64, 64, 1'b0);
    tile(0, 1, 64, 36, 1'b0);
    chk("rs_tiles_pre", tiles_seen, 1);
    pulse_start();
    chk("rs_tiles_post", tiles_seen, 0);
    chk("rs_busy", busy, 1);
    read_chk("rs_row0_clr", 0, 16'h0000);
    frame(1'b0);
    chk("rs_tiles", tiles_seen, 256);
    chk("rs_coord", coord_err, 0);
    chk("rs_mixed", mixed_err, 0);
    bitmap_chk("rs");

    // reset mid-frame
    pulse_start();
    tile(0, 0, 64, 64, 1'b0);
    tile(0, 1, 20, 6, 1'b0);
    pix(99, 99, 1'b1);
    chk("mr_coord_pre", coord_err, 1);
    resetn = 1'b0;
    @(negedge fastclock);
    resetn = 1'b1;
    chk("mr_rd_bits", rd_bits, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", frame_done, 0);
    chk("mr_coord", coord_err, 0);
    chk("mr_mixed", mixed_err, 0);
    chk("mr_tiles", tiles_seen, 0);
    tile(0, 0, 64, 64, 1'b0);
    chk("mr_idle_tiles", tiles_seen, 0);
    chk("mr_idle_busy", busy, 0);
    read_chk("mr_row0", 0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_tile_decoder.md
Name: plot_tile_decoder

Overview:
- Consumes the VGA plot stream (x, y, colour, plot) produced by our 16x16 tile bitmap renderers and rebuilds the 16x16 bitmap that generated it.
- Sits in parallel with vga_adapter, tapped off the same plot bus. It gives screen-compare checking and lets game logic read back what is on screen without a framebuffer read port.
- Flags any burst whose coordinates or colour contents do not match a legal tile burst.

Parameters:
- XPITCH, 10, horizontal tile pitch in pixels
- YPITCH, 7, vertical tile pitch in pixels
- FG_COLOUR, 3'b110, colour value counted as "lit"
- THRESH, 32, minimum lit pixels in a burst (out of 64) for the tile bit to be 1

Ports:
- fastclock  in  1  system clock
- resetn  in  1  reset
- start  in  1  one-cycle pulse; arms capture of a new frame
- plot  in  1  pixel write strobe
- x  in  8  pixel x
- y  in  7  pixel y
- colour  in  3  pixel colour
- rd_row  in  4  bitmap row to read
- rd_bits  out  16  row rd_rd_row registered; bit (15-col) = tile col
- busy  out  1  high in S_CAPTURE
- frame_done  out  1  high in S_DONE
- coord_err  out  1  sticky; some plot was off the expected raster position
- mixed_err  out  1  sticky; some committed tile had 0 < lit < 64
- tiles_seen  out  9  tiles committed this frame (0..256)

Reset: resetn, synchronous, active-low; clock fastclock.

Behaviour:
- Reset values:
  - State S_IDLE.
  - rd_bits, all bitmap rows, tiles_seen, coord_err and mixed_err are 0.
  - busy and frame_done are 0.
  - Internal counters (pix_cnt[5:0], lit_cnt[6:0], tile_col[3:0], tile_row[3:0], base_x[7:0], base_y[6:0]) are 0.
- States:
  - S_IDLE: start moves to S_CAPTURE. Plots are ignored.
  - S_CAPTURE: accepts plots. Moves to S_DONE on the edge that commits tile 256.
  - S_DONE: plots are ignored. start moves to S_CAPTURE.
- Entering S_CAPTURE (the start edge): clear the bitmap, tiles_seen, all counters, base_x, base_y, coord_err and mixed_err.
- start while in S_CAPTURE: same clear. The capture restarts and the partial burst is discarded.
- Per accepted plot (plot=1 in S_CAPTURE):
  - Expected position: exp_x = base_x + pix_cnt[2:0], exp_y = base_y + pix_cnt[5:3]. Additions are 8-bit and 7-bit, no saturation.
  - If x != exp_x or y != exp_y, set coord_err. The pixel is still counted.
  - lit_cnt increments when colour == FG_COLOUR.
  - pix_cnt increments.
- Gaps: plot may be low for any number of cycles between pixels. There is no timeout.
- Commit, on the same edge as the 64th accepted pixel (pix_cnt == 63 and plot):
  - Let lit_final = lit_cnt + (this pixel lit).
  - bitmap[tile_row][15-tile_col] <= (lit_final >= THRESH).
  - mixed_err is set if 0 < lit_final < 64.
  - lit_cnt <= 0, pix_cnt wraps to 0, tiles_seen increments.
- Tile advance, on the commit edge:
  - If tile_col != 15: tile_col+1 and base_x += XPITCH.
  - Else: tile_col = 0, base_x = 0, tile_row+1 and base_y += YPITCH.
  - The commit of tile_row 15, tile_col 15 goes to S_DONE, and tile_row wraps to 0.
- Readout:
  - rd_bits <= bitmap[rd_row] every cycle, in every state. Latency is 1 cycle.
  - If a row is read on the same edge it is written, the pre-write value is returned.
- Resource rule: no multipliers or dividers. All tile bases are accumulated by addition.
- resetn low mid-burst: full reset. The next frame needs a new start.

Decomposition:
- Shared package holds the tile geometry constants used by both renderer and decoder:
  - TILE_W = 8, TILE_H = 8, GRID_W = 16, GRID_H = 16
  - XPITCH/YPITCH defaults
  - the FG colour code 3'b110
- One natural sub-module, tile_burst_accum: pix_cnt, lit_cnt, expected-coordinate compare and commit strobe, with outputs commit, bit_val, mixed, coord_mismatch.
- The top holds the FSM, grid position/base accumulators, bitmap and readout.

Test Plan:
- Reset, then start, then a 256-tile burst stream encoding the "YOU WIN" pattern (row0 = 16'h8889, row12 = 16'h6C49, others per pattern), FG 3'b110 else 3'b000 -> frame_done = 1, tiles_seen = 256, rd_row = 0 gives rd_bits = 16'h8889 one cycle later, rd_row = 12 gives 16'h6C49, coord_err = 0, mixed_err = 0.
- Same stream with random 0-5 idle cycles between plots -> identical bitmap. busy stays high until the last pixel's edge, then frame_done.
- Tile 0 burst where pixel 9 has x = 3 (expected 1) -> coord_err = 1 after that edge. Tile 0 bit is still committed from its colour counts.
- Tile with exactly 32 FG pixels -> bit = 1 and mixed_err = 1. Tile with 31 FG pixels -> bit = 0 and mixed_err = 1.
- 100 pixels into a frame, pulse start -> tiles_seen = 1 just before the pulse, 0 one cycle after it. A fresh full frame then decodes correctly with no coord_err.
- Plots in S_IDLE and S_DONE -> no change to bitmap, tiles_seen or error flags. resetn low for 1 cycle mid-frame -> all outputs return to reset values and state is S_IDLE.
